// File: rtl/alu_flag_unit_pkg.sv
// Shared encodings for the ALU flag register and branch-condition resolver:
// op classes, condition codes, flag bit positions and FSM state encodings.
package alu_flag_unit_pkg;

    // ALU op classes; 2'b11 is reserved and behaves like CLS_NONE
    localparam logic [1:0] CLS_NONE  = 2'b00;
    localparam logic [1:0] CLS_LOGIC = 2'b01;
    localparam logic [1:0] CLS_ARITH = 2'b10;

    // Branch condition codes
    localparam logic [2:0] CCC_NEQ    = 3'b000;
    localparam logic [2:0] CCC_EQ     = 3'b001;
    localparam logic [2:0] CCC_GT     = 3'b010;
    localparam logic [2:0] CCC_LT     = 3'b011;
    localparam logic [2:0] CCC_GTE    = 3'b100;
    localparam logic [2:0] CCC_LTE    = 3'b101;
    localparam logic [2:0] CCC_OVFL   = 3'b110;
    localparam logic [2:0] CCC_UNCOND = 3'b111;

    // Bit positions inside the {Z,V,N} flag vector
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    // Query FSM states
    typedef enum logic [1:0] {
        FSM_IDLE = 2'd0,
        FSM_WAIT = 2'd1,
        FSM_RESP = 2'd2
    } fsm_state_e;

    // Plain-vector aliases of the states for the legacy-style state register
    localparam logic [1:0] ST_IDLE = FSM_IDLE;
    localparam logic [1:0] ST_WAIT = FSM_WAIT;
    localparam logic [1:0] ST_RESP = FSM_RESP;

    // True for the op classes that write at least one flag
    function automatic logic cls_writes_flags(input logic [1:0] cls);
        return (cls == CLS_LOGIC) || (cls == CLS_ARITH);
    endfunction

endpackage

// File: rtl/alu_flag_unit_branch_cond_eval.sv
// Purely combinational branch-condition evaluator: maps a condition code
// and a {Z,V,N} flag vector to a taken/not-taken decision.
module branch_cond_eval
    import alu_flag_unit_pkg::*;
(
    input  logic [2:0] ccc,
    input  logic [2:0] flags,
    output logic       taken
);

    logic z;
    logic v;
    logic n;

    assign z = flags[FLAG_Z];
    assign v = flags[FLAG_V];
    assign n = flags[FLAG_N];

    // Decode the condition code against the supplied flags
    always_comb begin
        taken = 1'b0;
        case (ccc)
            CCC_NEQ:    taken = ~z;
            CCC_EQ:     taken = z;
            CCC_GT:     taken = ~z & ~n;
            CCC_LT:     taken = n;
            CCC_GTE:    taken = z | ~n;
            CCC_LTE:    taken = n | z;
            CCC_OVFL:   taken = v;
            CCC_UNCOND: taken = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_flag_unit.sv
// Flag register and branch-condition resolver on the ALU result bus.
// Captures Z (logic ops) or Z/V/N (arith ops) and answers branch queries
// over a valid/ready handshake with a registered response.
// Optional macro FLAG_BYPASS_EN: a query accepted together with a flag write
// is evaluated against the incoming flags, so the WAIT state is never used.
module alu_flag_unit
    import alu_flag_unit_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             res_vld,
    input  logic [1:0]       res_cls,
    input  logic [WIDTH-1:0] result,
    input  logic             res_ovfl,
    input  logic             stall,
    input  logic             flush,
    input  logic             br_vld,
    input  logic [2:0]       br_ccc,
    output logic             br_rdy,
    output logic             br_done,
    output logic             br_taken,
    output logic [2:0]       flags
);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [2:0] flags_p1;
    logic [2:0] flags_nxt;
    logic [2:0] ccc_p1;
    logic       taken_p1;
    logic       flag_wr;
    logic       accept;
    logic       need_wait;
    logic [2:0] eval_ccc;
    logic [2:0] eval_flags;
    logic       eval_taken;

    assign flag_wr = res_vld & ~stall & cls_writes_flags(res_cls);
    assign br_rdy  = rst_n & ((state == ST_IDLE) | (state == ST_RESP)) & ~stall & ~flush;
    assign accept  = br_vld & br_rdy;

    // Incoming flag value: logic ops touch Z only, arith ops touch Z, V and N
    always_comb begin
        flags_nxt = flags_p1;
        if (flag_wr) begin
            flags_nxt[FLAG_Z] = (result == '0);
            if (res_cls == CLS_ARITH) begin
                flags_nxt[FLAG_V] = res_ovfl;
                flags_nxt[FLAG_N] = result[WIDTH-1];
            end
        end
    end

    // No query is accepted in WAIT, so the latched code can share the evaluator
    assign eval_ccc = (state == ST_WAIT) ? ccc_p1 : br_ccc;

`ifdef FLAG_BYPASS_EN
    assign eval_flags = flags_nxt;
    assign need_wait  = 1'b0;
`else
    assign eval_flags = flags_p1;
    assign need_wait  = flag_wr;
`endif

    branch_cond_eval u_eval (
        .ccc   (eval_ccc),
        .flags (eval_flags),
        .taken (eval_taken)
    );

    // Query FSM next state; flush wins over stall, stall freezes everything else
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_IDLE;
        end else if (!stall) begin
            case (state)
                ST_WAIT: state_nxt = ST_RESP;
                default: begin
                    if (accept) state_nxt = need_wait ? ST_WAIT : ST_RESP;
                    else        state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Control state, architectural flags and the registered branch answer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            flags_p1 <= 3'b000;
            taken_p1 <= 1'b0;
        end else begin
            state    <= state_nxt;
            flags_p1 <= flags_nxt;
            if (!stall && (accept || state == ST_WAIT)) begin
                taken_p1 <= eval_taken;
            end
        end
    end

    // Condition code held for evaluation after the conflicting flag write lands
    always_ff @(posedge clk) begin
        if (accept) begin
            ccc_p1 <= br_ccc;
        end
    end

    assign br_done  = rst_n & (state == ST_RESP) & ~stall & ~flush;
    assign br_taken = taken_p1;
    assign flags    = flags_p1;

endmodule
